// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller; raises the MEM-stage stall on miss.
// Latency: hits return data combinationally; clean miss stalls 1+mem+1 cycles, dirty miss adds a write-back round trip.
// Backpressure: p1_stall_o freezes the pipeline; mem_enable_o held until mem_ack_i. Optional counters: DCACHE_PERF_CNT_EN.
module dcache_stall_ctrl #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 5 - IDX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILL_DONE} stateT;
  stateT state, nextState;

  logic [TAG_W-1:0]  tagArr  [LINES];
  logic [LINE_W-1:0] dataArr [LINES];
  logic [LINES-1:0]  validArr;
  logic [LINES-1:0]  dirtyArr;

  logic [IDX-1:0]    lineIdx;
  logic [TAG_W-1:0]  lineTag;
  logic [2:0]        wordOff;
  logic              hit;
  logic              missIssue;
  logic              victimDirty;
  logic              writeHit;
  logic              refillDone;
  logic              unusedAddrBits;

  assign lineIdx        = p1_addr_i[5 +: IDX];
  assign lineTag        = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wordOff        = p1_addr_i[4:2];
  assign unusedAddrBits = ^p1_addr_i[1:0];

  assign hit         = p1_req_i & validArr[lineIdx] & (tagArr[lineIdx] == lineTag);
  assign missIssue   = p1_req_i & ~hit & (state == IDLE);
  assign victimDirty = validArr[lineIdx] & dirtyArr[lineIdx];
  assign writeHit    = p1_req_i & p1_write_i & hit & (state == IDLE);
  assign refillDone  = (state == REFILL) & mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (missIssue) nextState = victimDirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack_i) nextState = REFILL;
      REFILL:    if (mem_ack_i) nextState = FILL_DONE;
      FILL_DONE: nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    p1_stall_o = (p1_req_i & ~hit) | (state != IDLE);
    p1_data_o  = dataArr[lineIdx][{wordOff, 5'b0} +: 32];
  end

  // Control bits and memory-port registers; the CPU address is stable for the whole miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validArr     <= '0;
      dirtyArr     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      if (missIssue) begin
        mem_enable_o <= 1'b1;
        if (victimDirty) begin
          mem_write_o <= 1'b1;
          mem_addr_o  <= {tagArr[lineIdx], lineIdx, 5'b0};
          mem_data_o  <= dataArr[lineIdx];
        end else begin
          mem_write_o <= 1'b0;
          mem_addr_o  <= {lineTag, lineIdx, 5'b0};
        end
      end
      if ((state == WRITEBACK) && mem_ack_i) begin
        mem_write_o <= 1'b0;
        mem_addr_o  <= {lineTag, lineIdx, 5'b0};
      end
      if (refillDone) begin
        mem_enable_o      <= 1'b0;
        validArr[lineIdx] <= 1'b1;
        dirtyArr[lineIdx] <= 1'b0;
      end
      if (writeHit) dirtyArr[lineIdx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset so they can map onto RAM; a reset edge blocks any write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refillDone) begin
        dataArr[lineIdx] <= mem_data_i;
        tagArr[lineIdx]  <= lineTag;
      end else if (writeHit) begin
        dataArr[lineIdx][{wordOff, 5'b0} +: 32] <= p1_data_i;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (p1_req_i & hit & (state == IDLE)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (missIssue) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl: miss/refill timing, store hit, dirty eviction, reset mid-miss, stray ack.
module tb_dcache_stall_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p1_req_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_stall_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nFails  = 0;

  logic         txWrite [4];
  logic [31:0]  txAddr  [4];
  logic [255:0] txData  [4];
  int           nTx;

  task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; plays memory with the given latency and logs each request.
  task automatic doAccess(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, output int stalls, output logic [31:0] rdata);
    int  age;
    bit  done;
    age = 0; done = 0; stalls = 0; nTx = 0;
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdata;
    for (int c = 0; c < 200; c++) begin
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        age++;
        if (age == 1 && nTx < 4) begin
          txWrite[nTx] = mem_write_o; txAddr[nTx] = mem_addr_o; txData[nTx] = mem_data_o;
          nTx++;
        end
        if (age == lat) begin
          mem_ack_i = 1'b1;
          age = 0;
        end
      end
      #4;
      if (!p1_stall_o) begin
        done = 1;
        break;
      end
      stalls++;
      @(posedge clk_i); #1;
    end
    rdata = p1_data_o;
    if (!done) checkEq("access timeout", 256'(done), 256'd1);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    p1_req_i  = 1'b0;
    p1_write_i = 1'b0;
  endtask

  logic [255:0] fill1, fill2, dirtyLine;
  int           st;
  logic [31:0]  rd;

  initial begin
    for (int i = 0; i < 8; i++) begin
      fill1[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      fill2[i*32 +: 32] = 32'h2000_0000 + 32'(i);
    end
    dirtyLine = fill1;
    dirtyLine[63:32] = 32'hDEAD_BEEF;

    rst_i = 1'b1; p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkEq("rst mem_enable", 256'(mem_enable_o), 256'd0);
    checkEq("rst mem_write", 256'(mem_write_o), 256'd0);
    checkEq("rst mem_addr", 256'(mem_addr_o), 256'd0);
    checkEq("rst mem_data", mem_data_o, 256'd0);
    checkEq("rst valid", 256'(dut.validArr), 256'd0);
    rst_i = 1'b0;
    p1_req_i = 1'b1; p1_addr_i = 32'h40;
    #1;
    checkEq("rst req stalls", 256'(p1_stall_o), 256'd1);
    p1_req_i = 1'b0;
    #1;
    checkEq("idle no stall", 256'(p1_stall_o), 256'd0);
    @(posedge clk_i); #1;

    // Clean miss, 10-cycle memory.
    mem_data_i = fill1;
    doAccess(1'b0, 32'h40, 32'h0, 10, st, rd);
    checkEq("t1 stall cycles", 256'(st), 256'd12);
    checkEq("t1 mem requests", 256'(nTx), 256'd1);
    checkEq("t1 refill write", 256'(txWrite[0]), 256'd0);
    checkEq("t1 refill addr", 256'(txAddr[0]), 256'h40);
    checkEq("t1 load data", 256'(rd), 256'h1000_0000);
    checkEq("t1 enable dropped", 256'(mem_enable_o), 256'd0);

    // Store hit then load back.
    doAccess(1'b1, 32'h44, 32'hDEAD_BEEF, 10, st, rd);
    checkEq("t2 store stalls", 256'(st), 256'd0);
    checkEq("t2 dirty[2]", 256'(dut.dirtyArr[2]), 256'd1);
    doAccess(1'b0, 32'h44, 32'h0, 10, st, rd);
    checkEq("t2 load stalls", 256'(st), 256'd0);
    checkEq("t2 load data", 256'(rd), 256'hDEAD_BEEF);

    // Conflict miss on a dirty line, 3-cycle memory.
    mem_data_i = fill2;
    doAccess(1'b0, 32'h444, 32'h0, 3, st, rd);
    checkEq("t3 stall cycles", 256'(st), 256'd8);
    checkEq("t3 mem requests", 256'(nTx), 256'd2);
    checkEq("t3 wb write", 256'(txWrite[0]), 256'd1);
    checkEq("t3 wb addr", 256'(txAddr[0]), 256'h40);
    checkEq("t3 wb data", txData[0], dirtyLine);
    checkEq("t3 refill write", 256'(txWrite[1]), 256'd0);
    checkEq("t3 refill addr", 256'(txAddr[1]), 256'h440);
    checkEq("t3 load data", 256'(rd), 256'h2000_0001);
    checkEq("t3 dirty[2]", 256'(dut.dirtyArr[2]), 256'd0);
`ifdef DCACHE_PERF_CNT_EN
    checkEq("perf miss_cnt", 256'(miss_cnt_o), 256'd2);
    checkEq("perf hit_cnt", 256'(hit_cnt_o), 256'd4);
`endif

    // Reset while a refill is outstanding.
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h880;
    @(posedge clk_i); #1;
    checkEq("t4 enable issued", 256'(mem_enable_o), 256'd1);
    checkEq("t4 refill addr", 256'(mem_addr_o), 256'h880);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkEq("t4 rst enable", 256'(mem_enable_o), 256'd0);
    checkEq("t4 rst valid", 256'(dut.validArr), 256'd0);
    checkEq("t4 rst mem_data", mem_data_o, 256'd0);
    rst_i = 1'b0; p1_req_i = 1'b0;
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #3;
    checkEq("t4 late ack enable", 256'(mem_enable_o), 256'd0);
    checkEq("t4 late ack stall", 256'(p1_stall_o), 256'd0);
    checkEq("t4 late ack valid", 256'(dut.validArr), 256'd0);
    p1_req_i = 1'b1; p1_addr_i = 32'h444;
    #1;
    checkEq("t4 line invalid", 256'(p1_stall_o), 256'd1);
    p1_req_i = 1'b0;
    @(posedge clk_i); #1;

    // Stray ack in IDLE.
    mem_data_i = fill1;
    doAccess(1'b0, 32'h40, 32'h0, 2, st, rd);
    checkEq("t5 refill stalls", 256'(st), 256'd4);
    mem_data_i = fill2;
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #3;
    checkEq("t5 enable", 256'(mem_enable_o), 256'd0);
    checkEq("t5 write", 256'(mem_write_o), 256'd0);
    checkEq("t5 addr held", 256'(mem_addr_o), 256'h40);
    checkEq("t5 stall", 256'(p1_stall_o), 256'd0);
    @(posedge clk_i); #1;
    doAccess(1'b0, 32'h5C, 32'h0, 2, st, rd);
    checkEq("t5 hit stalls", 256'(st), 256'd0);
    checkEq("t5 array intact", 256'(rd), 256'h1000_0007);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
